// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: decode-stage immediate extender feeding an in-order output queue.
// Latency: one cycle from an accepted push to the entry appearing at the head of an empty queue.
// Backpressure: in_ready drops only at full occupancy and is derived from registered state only.
// Optional feature: define IMMEXT_UPPER_EN to enable upper placement for mode 2'b10;
// otherwise mode 2'b10 is treated like the reserved mode 2'b11.

// imm_extend_fifo: generic in-order queue; an empty queue presents all-zero read data.
// Latency: a write is visible at the read side one cycle later; there is no bypass path.
// Backpressure: wr_ready = not full, computed from registered state; a full queue refuses a write even when a read happens in the same cycle.
module imm_extend_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [W-1:0]               wr_data,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [W-1:0]               rd_data,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] count;
  logic             do_wr;
  logic             do_rd;

  assign wr_ready = (count != FULL_LVL);
  assign rd_valid = (count != '0);
  assign do_wr    = wr_valid && wr_ready;
  assign do_rd    = rd_valid && rd_ready;
  assign level    = count;

  // The head is only presented while an entry exists, so stale storage never leaks out.
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

  // Pointer and occupancy bookkeeping; reset discards every queued entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset because occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

endmodule

// imm_extend_pipe: sign/zero/upper immediate extension followed by a DEPTH-entry output queue.
// Latency: a push in cycle N shows up as out_valid in cycle N+1 when the queue was empty.
// Backpressure: out_ready stalls are absorbed by the queue; in_ready deasserts only at full occupancy.
module imm_extend_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [IN_W-1:0]            in_data,
  input  logic [1:0]                 in_mode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_W-1:0]           out_data,
  output logic                       out_err,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int PAD = OUT_W - IN_W;

  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] zext;
  logic [OUT_W-1:0] ext_data;
  logic             ext_err;
  logic [OUT_W:0]   q_rd_data;

  // Width-dependent extension candidates; a zero pad degenerates to pass-through.
  if (PAD > 0) begin : g_pad
    assign sext = {{PAD{in_data[IN_W-1]}}, in_data};
    assign zext = {{PAD{1'b0}}, in_data};
  end else begin : g_nopad
    assign sext = in_data;
    assign zext = in_data;
  end

`ifdef IMMEXT_UPPER_EN
  logic [OUT_W-1:0] uext;

  if (PAD > 0) begin : g_upad
    assign uext = {in_data, {PAD{1'b0}}};
  end else begin : g_unopad
    assign uext = in_data;
  end
`endif

  // Mode decode: select the extended value and flag illegal modes with zeroed data.
  always_comb begin
    ext_data = '0;
    ext_err  = 1'b0;
    case (in_mode)
      2'b00: ext_data = sext;
      2'b01: ext_data = zext;
`ifdef IMMEXT_UPPER_EN
      2'b10: ext_data = uext;
`else
      2'b10: ext_err  = 1'b1;
`endif
      default: ext_err = 1'b1;
    endcase
  end

  // The error flag rides alongside the operand in the top bit of each queue entry.
  imm_extend_fifo #(
    .W     (OUT_W + 1),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (in_valid),
    .wr_ready (in_ready),
    .wr_data  ({ext_err, ext_data}),
    .rd_valid (out_valid),
    .rd_ready (out_ready),
    .rd_data  (q_rd_data),
    .level    (level)
  );

  assign out_err  = q_rd_data[OUT_W];
  assign out_data = q_rd_data[OUT_W-1:0];

endmodule
